beta_fetch_stage_ctrl: RTL

Instruction-fetch stage controller for the Bourbon 3-stage pipeline. It is the stage-side end of the pipeline control handshake: it consumes the fetch enable and pipe-0 stall from the pipeline control unit, reports busy back to it, and runs one instruction-memory transaction per fetch. It owns the program counter, accepts redirects from the execution stage, and presents the fetched instruction and its PC to the if-to-dec pipe.

---
 rtl/beta_fetch_stage_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/beta_fetch_stage_ctrl.sv
// Instruction-fetch stage controller: owns the PC, runs one imem transaction per fetch,
// honours execution-stage redirects. Optional misaligned-redirect fault: BETA_IFS_MISALIGN_CHECK_EN.
module beta_fetch_stage_ctrl #(
    parameter int unsigned                DataWidth = 32,
    parameter logic [DataWidth-1:0]       BootAddr  = {DataWidth{1'b0}}
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  pcu_ifs_fetch_en_i,
    input  logic                  pcu_pip0_stall_i,
    output logic                  pcu_ifs_busy_o,
    output logic                  imem_req_o,
    output logic [DataWidth-1:0]  imem_addr_o,
    input  logic                  imem_gnt_i,
    input  logic                  imem_rvalid_i,
    input  logic [DataWidth-1:0]  imem_rdata_i,
    input  logic                  redirect_valid_i,
    input  logic [DataWidth-1:0]  redirect_addr_i,
    output logic [DataWidth-1:0]  ifs_instr_o,
    output logic [DataWidth-1:0]  ifs_pc_o,
    output logic                  ifs_valid_o,
    output logic                  ifs_fault_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10
    } state_e;

    localparam logic [DataWidth-1:0] NopInstr = DataWidth'(32'h0000_0013);
    localparam logic [DataWidth-1:0] PcInc    = DataWidth'(32'h0000_0004);

    state_e                 state_r;
    logic [DataWidth-1:0]   pc_r;
    logic [DataWidth-1:0]   addr_r;
    logic [DataWidth-1:0]   instr_r;
    logic [DataWidth-1:0]   ifs_pc_r;
    logic                   req_r;
    logic                   busy_r;
    logic                   valid_r;
    logic                   fault_r;
    logic                   killed_r;

    logic [DataWidth-1:0]   redir_addr_s;
    logic                   bad_redirect_s;
    logic                   good_redirect_s;
    logic                   fetch_ok_s;

`ifdef BETA_IFS_MISALIGN_CHECK_EN
    assign redir_addr_s   = redirect_addr_i;
    assign bad_redirect_s = redirect_valid_i & (redirect_addr_i[1:0] != 2'b00);
`else
    assign redir_addr_s   = {redirect_addr_i[DataWidth-1:2], 2'b00};
    assign bad_redirect_s = 1'b0;
`endif

    // A misaligned redirect both faults and blocks a fetch accepted in the same cycle.
    always_comb begin
        good_redirect_s = redirect_valid_i & ~bad_redirect_s;
        fetch_ok_s      = pcu_ifs_fetch_en_i & ~pcu_pip0_stall_i & ~fault_r & ~bad_redirect_s;
    end

    // Fetch FSM, PC and all registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_r  <= IDLE;
            pc_r     <= BootAddr;
            addr_r   <= BootAddr;
            instr_r  <= NopInstr;
            ifs_pc_r <= {DataWidth{1'b0}};
            req_r    <= 1'b0;
            busy_r   <= 1'b0;
            valid_r  <= 1'b0;
            fault_r  <= 1'b0;
            killed_r <= 1'b0;
        end else begin
            if (redirect_valid_i) begin
                valid_r <= 1'b0;
            end
            if (good_redirect_s) begin
                pc_r <= redir_addr_s;
            end
            if (bad_redirect_s) begin
                fault_r <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    killed_r <= 1'b0;
                    if (fetch_ok_s) begin
                        state_r <= REQ;
                        req_r   <= 1'b1;
                        busy_r  <= 1'b1;
                        addr_r  <= good_redirect_s ? redir_addr_s : pc_r;
                    end
                end
                REQ: begin
                    // The request still completes at the old address; its response is dropped.
                    if (redirect_valid_i) begin
                        killed_r <= 1'b1;
                    end
                    if (imem_gnt_i) begin
                        state_r <= WAIT;
                        req_r   <= 1'b0;
                    end
                end
                WAIT: begin
                    if (imem_rvalid_i) begin
                        state_r  <= IDLE;
                        busy_r   <= 1'b0;
                        killed_r <= 1'b0;
                        if (!killed_r && !redirect_valid_i) begin
                            instr_r  <= imem_rdata_i;
                            ifs_pc_r <= pc_r;
                            valid_r  <= 1'b1;
                            pc_r     <= pc_r + PcInc;
                        end
                    end else if (redirect_valid_i) begin
                        killed_r <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    req_r    <= 1'b0;
                    busy_r   <= 1'b0;
                    killed_r <= 1'b0;
                end
            endcase
        end
    end

    assign pcu_ifs_busy_o = busy_r;
    assign imem_req_o     = req_r;
    assign imem_addr_o    = addr_r;
    assign ifs_instr_o    = instr_r;
    assign ifs_pc_o       = ifs_pc_r;
    assign ifs_valid_o    = valid_r;
    assign ifs_fault_o    = fault_r;

endmodule
